turf_multi_cmd_ctrl_port: RTL and testbench

//  Next-generation TURF event control UDP port. Executes up to MAX_CMDS 64-bit commands per packet, not just the first.

---
 rtl/turf_ctrl_pkg.sv | 24 ++
 rtl/turf_ctrl_resp_buf.sv | 44 ++++
 rtl/turf_multi_cmd_ctrl_port.sv | 196 +++++++++++++++++++
 tb/tb_turf_multi_cmd_ctrl_port.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_ctrl_pkg.sv
// Shared command codes, FSM state type and UDP header field offsets for the TURF control port.
package turf_ctrl_pkg;

  localparam logic [15:0] CMD_OP = 16'h4F50;
  localparam logic [15:0] CMD_CL = 16'h434C;
  localparam logic [15:0] CMD_ID = 16'h4944;
  localparam logic [15:0] CMD_PR = 16'h5052;
  localparam logic [15:0] CMD_PW = 16'h5057;
  localparam logic [15:0] CMD_ER = 16'h4552;
  localparam logic [15:0] CMD_ST = 16'h5354;

  localparam int unsigned HDR_IP_LSB   = 32;
  localparam int unsigned HDR_PORT_LSB = 16;
  localparam int unsigned HDR_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    READ_CMD,
    DUMP,
    WRITE_HEADER,
    WRITE_PAYLOAD
  } state_e;

endpackage

// File: rtl/turf_ctrl_resp_buf.sv
// Write-then-drain response buffer: fills during a request, drains in order during the reply.
module turf_ctrl_resp_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [63:0]              wr_data_i,
  input  logic                     rd_adv_i,
  output logic [63:0]              rd_data_o,
  output logic                     rd_last_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [63:0]      mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_q;
  logic             full;

  assign full = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge aclk) begin
    if (!aresetn || clear_i) begin
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      if (wr_en_i && !full) count_q <= count_q + CNT_W'(1);
      if (rd_adv_i)         rd_q    <= rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en_i && !full) mem_q[count_q[PTR_W-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_q];
  assign rd_last_o = (({1'b0, rd_q} + CNT_W'(1)) == count_q);
  assign count_o   = count_q;

endmodule

// File: rtl/turf_multi_cmd_ctrl_port.sv
// TURF event control UDP port: runs up to MAX_CMDS commands per packet and replies with one packet.
// Optional TURF_CTRL_STATS_EN adds the "ST" statistics command.
module turf_multi_cmd_ctrl_port
  import turf_ctrl_pkg::*;
#(
  parameter logic [47:0] MY_MAC_ADDRESS    = 48'h0200_0000_0000,
  parameter int unsigned MAX_FRAGMENT_LEN  = 1023,
  parameter int unsigned MAX_CMDS          = 8,
  parameter logic [9:0]  DEFAULT_NFRAGMENT = 10'd127
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_udphdr_tdata,
  input  logic        s_udphdr_tvalid,
  output logic        s_udphdr_tready,
  input  logic [63:0] s_udpdata_tdata,
  input  logic [7:0]  s_udpdata_tkeep,
  input  logic        s_udpdata_tlast,
  input  logic        s_udpdata_tvalid,
  output logic        s_udpdata_tready,
  output logic [63:0] m_udphdr_tdata,
  output logic        m_udphdr_tvalid,
  input  logic        m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tlast,
  output logic        m_udpdata_tvalid,
  input  logic        m_udpdata_tready,
  output logic [9:0]  nfragment_count_o,
  output logic [31:0] event_ip_o,
  output logic [15:0] event_port_o,
  output logic        event_open_o
);

  localparam int unsigned CNT_W    = $clog2(MAX_CMDS) + 1;
  localparam logic [9:0]  FRAG_MAX = 10'(MAX_FRAGMENT_LEN);

  state_e           state_q, state_d;
  logic [31:0]      ip_q;
  logic [15:0]      port_q;
  logic [31:0]      ev_ip_q;
  logic [15:0]      ev_port_q;
  logic             open_q;
  logic [9:0]       nfrag_q;

  logic             exec;
  logic [15:0]      cmd;
  logic [9:0]       pw_new;
  logic [63:0]      resp;
  logic [CNT_W-1:0] cnt_after;

  logic             buf_clr, buf_adv;
  logic [63:0]      buf_rd_data;
  logic             buf_rd_last;
  logic [CNT_W-1:0] buf_count;

  logic             unused_hdr_len;
  assign unused_hdr_len = ^s_udphdr_tdata[HDR_LEN_LSB +: 16];

`ifdef TURF_CTRL_STATS_EN
  logic [15:0] rx_q, err_q;
`endif

  assign cmd       = s_udpdata_tdata[15:0];
  assign cnt_after = buf_count + CNT_W'(exec);

  always_comb begin
    state_d          = state_q;
    s_udphdr_tready  = 1'b0;
    s_udpdata_tready = 1'b0;
    m_udphdr_tvalid  = 1'b0;
    m_udpdata_tvalid = 1'b0;
    exec             = 1'b0;
    buf_clr          = 1'b0;
    buf_adv          = 1'b0;
    case (state_q)
      IDLE: begin
        s_udphdr_tready = 1'b1;
        if (s_udphdr_tvalid) state_d = READ_CMD;
      end
      READ_CMD: begin
        s_udpdata_tready = 1'b1;
        if (s_udpdata_tvalid) begin
          exec = (s_udpdata_tkeep == 8'hFF);
          if (s_udpdata_tlast)
            state_d = (cnt_after != '0) ? WRITE_HEADER : IDLE;
          else if (exec && cnt_after == CNT_W'(MAX_CMDS))
            state_d = DUMP;
        end
      end
      DUMP: begin
        s_udpdata_tready = 1'b1;
        if (s_udpdata_tvalid && s_udpdata_tlast)
          state_d = (buf_count != '0) ? WRITE_HEADER : IDLE;
      end
      WRITE_HEADER: begin
        m_udphdr_tvalid = 1'b1;
        if (m_udphdr_tready) state_d = WRITE_PAYLOAD;
      end
      WRITE_PAYLOAD: begin
        m_udpdata_tvalid = 1'b1;
        if (m_udpdata_tready) begin
          buf_adv = 1'b1;
          if (buf_rd_last) begin
            buf_clr = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses are formed from registered state, so earlier commands in the packet are visible.
  always_comb begin
    pw_new = (s_udpdata_tdata[25:16] > FRAG_MAX) ? FRAG_MAX : s_udpdata_tdata[25:16];
    resp   = {s_udpdata_tdata[63:16], CMD_ER};
    case (cmd)
      CMD_OP: resp = {ip_q, port_q, CMD_OP};
      CMD_CL: resp = {48'h0, CMD_CL};
      CMD_ID: resp = {MY_MAC_ADDRESS, CMD_ID};
      CMD_PR: resp = {38'h0, nfrag_q, CMD_PR};
      CMD_PW: resp = {38'h0, pw_new, CMD_PW};
`ifdef TURF_CTRL_STATS_EN
      CMD_ST: resp = {16'h0, rx_q, err_q, CMD_ST};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ip_q      <= '0;
      port_q    <= '0;
      ev_ip_q   <= '0;
      ev_port_q <= '0;
      open_q    <= 1'b0;
      nfrag_q   <= DEFAULT_NFRAGMENT;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && s_udphdr_tvalid) begin
        ip_q   <= s_udphdr_tdata[HDR_IP_LSB +: 32];
        port_q <= s_udphdr_tdata[HDR_PORT_LSB +: 16];
      end
      if (exec) begin
        case (cmd)
          CMD_OP: begin
            ev_ip_q   <= ip_q;
            ev_port_q <= port_q;
            open_q    <= 1'b1;
          end
          CMD_CL:  open_q  <= 1'b0;
          CMD_PW:  nfrag_q <= pw_new;
          default: ;
        endcase
      end
    end
  end

`ifdef TURF_CTRL_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_q  <= '0;
      err_q <= '0;
    end else begin
      if (state_q == IDLE && s_udphdr_tvalid) rx_q  <= rx_q + 16'd1;
      if (exec && resp[15:0] == CMD_ER)       err_q <= err_q + 16'd1;
    end
  end
`endif

  turf_ctrl_resp_buf #(
    .DEPTH (MAX_CMDS)
  ) u_resp_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear_i   (buf_clr),
    .wr_en_i   (exec),
    .wr_data_i (resp),
    .rd_adv_i  (buf_adv),
    .rd_data_o (buf_rd_data),
    .rd_last_o (buf_rd_last),
    .count_o   (buf_count)
  );

  assign m_udphdr_tdata    = {ip_q, port_q, 16'({buf_count, 3'b000})};
  assign m_udpdata_tdata   = buf_rd_data;
  assign m_udpdata_tkeep   = 8'hFF;
  assign m_udpdata_tlast   = buf_rd_last;
  assign nfragment_count_o = nfrag_q;
  assign event_ip_o        = ev_ip_q;
  assign event_port_o      = ev_port_q;
  assign event_open_o      = open_q;

endmodule

// File: tb/tb_turf_multi_cmd_ctrl_port.sv
// Randomised scoreboard bench for turf_multi_cmd_ctrl_port against a packet-level reference model.
module tb_turf_multi_cmd_ctrl_port;

  localparam logic [47:0] MAC  = 48'h0200_0000_0000;
  localparam int unsigned MAXC = 8;
  localparam int unsigned MAXF = 511;
  localparam logic [15:0] T_OP = "OP";
  localparam logic [15:0] T_CL = "CL";
  localparam logic [15:0] T_ID = "ID";
  localparam logic [15:0] T_PR = "PR";
  localparam logic [15:0] T_PW = "PW";
  localparam logic [15:0] T_ST = "ST";
  localparam logic [15:0] T_ER = "ER";

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_udphdr_tdata = '0;
  logic        s_udphdr_tvalid = 1'b0;
  logic        s_udphdr_tready;
  logic [63:0] s_udpdata_tdata = '0;
  logic [7:0]  s_udpdata_tkeep = '0;
  logic        s_udpdata_tlast = 1'b0;
  logic        s_udpdata_tvalid = 1'b0;
  logic        s_udpdata_tready;
  logic [63:0] m_udphdr_tdata;
  logic        m_udphdr_tvalid;
  logic        m_udphdr_tready = 1'b1;
  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tlast;
  logic        m_udpdata_tvalid;
  logic        m_udpdata_tready = 1'b1;
  logic [9:0]  nfragment_count_o;
  logic [31:0] event_ip_o;
  logic [15:0] event_port_o;
  logic        event_open_o;

  turf_multi_cmd_ctrl_port #(
    .MY_MAC_ADDRESS    (MAC),
    .MAX_FRAGMENT_LEN  (MAXF),
    .MAX_CMDS          (MAXC),
    .DEFAULT_NFRAGMENT (10'd127)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_udphdr_tdata    (s_udphdr_tdata),
    .s_udphdr_tvalid   (s_udphdr_tvalid),
    .s_udphdr_tready   (s_udphdr_tready),
    .s_udpdata_tdata   (s_udpdata_tdata),
    .s_udpdata_tkeep   (s_udpdata_tkeep),
    .s_udpdata_tlast   (s_udpdata_tlast),
    .s_udpdata_tvalid  (s_udpdata_tvalid),
    .s_udpdata_tready  (s_udpdata_tready),
    .m_udphdr_tdata    (m_udphdr_tdata),
    .m_udphdr_tvalid   (m_udphdr_tvalid),
    .m_udphdr_tready   (m_udphdr_tready),
    .m_udpdata_tdata   (m_udpdata_tdata),
    .m_udpdata_tkeep   (m_udpdata_tkeep),
    .m_udpdata_tlast   (m_udpdata_tlast),
    .m_udpdata_tvalid  (m_udpdata_tvalid),
    .m_udpdata_tready  (m_udpdata_tready),
    .nfragment_count_o (nfragment_count_o),
    .event_ip_o        (event_ip_o),
    .event_port_o      (event_port_o),
    .event_open_o      (event_open_o)
  );

  always #5 aclk = ~aclk;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [63:0] exp_hdr[$];
  logic [64:0] exp_dat[$];

  logic [31:0] md_ip = '0;
  logic [15:0] md_port = '0;
  logic        md_open = 1'b0;
  logic [9:0]  md_nfrag = 10'd127;
  logic [15:0] md_rx = '0;
  logic [15:0] md_err = '0;

  logic [63:0] pd [16];
  logic [7:0]  pk [16];

  int unsigned rmode = 3;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail1(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s actual=event required=no_event", nm);
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0: begin
          m_udpdata_tready = 1'($urandom_range(0, 1));
          m_udphdr_tready  = 1'($urandom_range(0, 1));
        end
        1: begin
          m_udpdata_tready = ~m_udpdata_tready;
          m_udphdr_tready  = 1'b1;
        end
        2: begin
          m_udpdata_tready = 1'b0;
          m_udphdr_tready  = 1'b1;
        end
        default: begin
          m_udpdata_tready = 1'b1;
          m_udphdr_tready  = 1'b1;
        end
      endcase
    end
  end

  // Monitor: handshakes are decided at the next rising edge, so sample on the falling edge.
  logic        hstall = 1'b0, dstall = 1'b0;
  logic [63:0] hprev;
  logic [64:0] dprev;
  always @(negedge aclk) begin
    if (!aresetn) begin
      hstall = 1'b0;
      dstall = 1'b0;
    end else begin
      if (m_udphdr_tvalid) begin
        if (hstall) chk("hdr_stable", {8'h0, m_udphdr_tdata}, {8'h0, hprev});
        if (m_udphdr_tready) begin
          if (exp_hdr.size() == 0) fail1("hdr_unexpected");
          else chk("hdr", {8'h0, m_udphdr_tdata}, {8'h0, exp_hdr.pop_front()});
          hstall = 1'b0;
        end else begin
          hstall = 1'b1;
          hprev  = m_udphdr_tdata;
        end
      end else if (hstall) begin
        fail1("hdr_valid_dropped");
        hstall = 1'b0;
      end
      if (m_udpdata_tvalid) begin
        chk("keep", {64'h0, m_udpdata_tkeep}, {64'h0, 8'hFF});
        if (dstall) chk("dat_stable", {7'h0, m_udpdata_tlast, m_udpdata_tdata}, {7'h0, dprev});
        if (m_udpdata_tready) begin
          if (exp_dat.size() == 0) fail1("dat_unexpected");
          else chk("dat", {7'h0, m_udpdata_tlast, m_udpdata_tdata}, {7'h0, exp_dat.pop_front()});
          dstall = 1'b0;
        end else begin
          dstall = 1'b1;
          dprev  = {m_udpdata_tlast, m_udpdata_tdata};
        end
      end else if (dstall) begin
        fail1("dat_valid_dropped");
        dstall = 1'b0;
      end
    end
  end

  task automatic model_reset();
    md_ip = '0; md_port = '0; md_open = 1'b0; md_nfrag = 10'd127; md_rx = '0; md_err = '0;
  endtask

  task automatic model_pkt(input logic [31:0] ip, input logic [15:0] port, input int unsigned n);
    logic [63:0] rq[$];
    logic [63:0] r, d;
    logic [9:0]  v;
    bit          dumping = 0;
    md_rx++;
    for (int unsigned i = 0; i < n; i++) begin
      d = pd[i];
      if (!dumping && pk[i] == 8'hFF) begin
        case (d[15:0])
          T_OP: begin md_ip = ip; md_port = port; md_open = 1'b1; r = {ip, port, T_OP}; end
          T_CL: begin md_open = 1'b0; r = {48'h0, T_CL}; end
          T_ID: r = {MAC, T_ID};
          T_PR: r = {38'h0, md_nfrag, T_PR};
          T_PW: begin
            v = d[25:16];
            md_nfrag = (int'(v) > MAXF) ? 10'(MAXF) : v;
            r = {38'h0, md_nfrag, T_PW};
          end
`ifdef TURF_CTRL_STATS_EN
          T_ST: r = {16'h0, md_rx, md_err, T_ST};
`endif
          default: begin r = {d[63:16], T_ER}; md_err++; end
        endcase
        rq.push_back(r);
        if (rq.size() == MAXC && i != n - 1) dumping = 1;
      end
    end
    if (rq.size() > 0) begin
      exp_hdr.push_back({ip, port, 16'(rq.size() * 8)});
      for (int unsigned i = 0; i < rq.size(); i++)
        exp_dat.push_back({(i == rq.size() - 1), rq[i]});
    end
  endtask

  task automatic wait_hs(input bit is_hdr, output bit ok);
    int unsigned n = 0;
    ok = 1;
    forever begin
      @(negedge aclk);
      if (is_hdr ? s_udphdr_tready : s_udpdata_tready) break;
      n++;
      if (n > 2000) begin
        fail1(is_hdr ? "hdr_ready_timeout" : "dat_ready_timeout");
        ok = 0;
        return;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input logic [31:0] ip, input logic [15:0] port, input int unsigned n);
    bit ok;
    model_pkt(ip, port, n);
    @(posedge aclk);
    #1;
    s_udphdr_tdata  = {ip, port, 16'(n * 8)};
    s_udphdr_tvalid = 1'b1;
    wait_hs(1, ok);
    s_udphdr_tvalid = 1'b0;
    if (!ok) return;
    for (int unsigned i = 0; i < n; i++) begin
      s_udpdata_tdata  = pd[i];
      s_udpdata_tkeep  = pk[i];
      s_udpdata_tlast  = (i == n - 1);
      s_udpdata_tvalid = 1'b1;
      wait_hs(0, ok);
      if (!ok) break;
    end
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
  endtask

  task automatic wait_done_and_check();
    int unsigned n = 0;
    forever begin
      @(negedge aclk);
      if (exp_hdr.size() == 0 && exp_dat.size() == 0 && s_udphdr_tready) break;
      n++;
      if (n > 3000) begin
        fail1("reply_timeout");
        exp_hdr.delete();
        exp_dat.delete();
        break;
      end
    end
    chk("event_ip", {40'h0, event_ip_o}, {40'h0, md_ip});
    chk("event_port", {56'h0, event_port_o}, {56'h0, md_port});
    chk("event_open", {71'h0, event_open_o}, {71'h0, md_open});
    chk("nfragment", {62'h0, nfragment_count_o}, {62'h0, md_nfrag});
  endtask

  function automatic logic [63:0] rand_cmd();
    logic [63:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: d[15:0] = T_OP;
      1: d[15:0] = T_CL;
      2: d[15:0] = T_ID;
      3: d[15:0] = T_PR;
      4, 5: d[15:0] = T_PW;
      6: d[15:0] = T_ST;
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    int unsigned n, w;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_hdr_tvalid", {71'h0, m_udphdr_tvalid}, 72'h0);
    chk("rst_dat_tvalid", {71'h0, m_udpdata_tvalid}, 72'h0);
    chk("rst_nfragment", {62'h0, nfragment_count_o}, 72'd127);
    chk("rst_event_ip", {40'h0, event_ip_o}, 72'h0);
    chk("rst_open", {71'h0, event_open_o}, 72'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_idle_ready", {71'h0, s_udphdr_tready}, 72'h1);

    // OP then PR: PR reflects state after OP
    pd[0] = {48'h0, T_OP}; pk[0] = 8'hFF;
    pd[1] = {48'h0, T_PR}; pk[1] = 8'hFF;
    send_pkt(32'h0A00_0001, 16'h1234, 2);
    wait_done_and_check();
    chk("t1_ip", {40'h0, event_ip_o}, {40'h0, 32'h0A00_0001});
    chk("t1_port", {56'h0, event_port_o}, {56'h0, 16'h1234});
    chk("t1_open", {71'h0, event_open_o}, 72'h1);

    // PW clamps to MAX_FRAGMENT_LEN
    pd[0] = {38'h0, 10'h3FF, T_PW}; pk[0] = 8'hFF;
    pd[1] = {48'h0, T_PR};          pk[1] = 8'hFF;
    send_pkt(32'hC0A8_0102, 16'h0050, 2);
    wait_done_and_check();
    chk("t2_nfrag", {62'h0, nfragment_count_o}, 72'd511);

    // 10 commands, only MAX_CMDS executed
    for (int unsigned i = 0; i < 10; i++) begin pd[i] = {48'h0, T_ID}; pk[i] = 8'hFF; end
    send_pkt(32'h0101_0101, 16'h0F0F, 10);
    wait_done_and_check();

    // Partial-keep only: no reply
    pd[0] = {48'h0, T_ID}; pk[0] = 8'h0F;
    send_pkt(32'h0202_0202, 16'h0001, 1);
    repeat (10) @(posedge aclk);
    wait_done_and_check();

    // Stalled 3-word reply
    rmode = 1;
    pd[0] = {48'h0, T_ID}; pk[0] = 8'hFF;
    pd[1] = {48'h0, T_CL}; pk[1] = 8'hFF;
    pd[2] = {48'h0, T_PR}; pk[2] = 8'hFF;
    send_pkt(32'h0303_0303, 16'h2222, 3);
    wait_done_and_check();

    rmode = 0;
    for (int unsigned p = 0; p < 40; p++) begin
      n = $urandom_range(1, 11);
      for (int unsigned i = 0; i < n; i++) begin
        pd[i] = rand_cmd();
        pk[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      end
      send_pkt($urandom, 16'($urandom), n);
      wait_done_and_check();
    end

    // Reset while the reply is stalled in the payload phase
    rmode = 2;
    pd[0] = {48'h0, T_OP};          pk[0] = 8'hFF;
    pd[1] = {38'h0, 10'h055, T_PW}; pk[1] = 8'hFF;
    pd[2] = {48'h0, T_ID};          pk[2] = 8'hFF;
    send_pkt(32'h0404_0404, 16'h4444, 3);
    w = 0;
    while (!m_udpdata_tvalid && w < 200) begin @(negedge aclk); w++; end
    if (!m_udpdata_tvalid) fail1("t6_payload_timeout");
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    exp_hdr.delete();
    exp_dat.delete();
    model_reset();
    @(posedge aclk);
    #1;
    chk("t6_hdr_tvalid", {71'h0, m_udphdr_tvalid}, 72'h0);
    chk("t6_dat_tvalid", {71'h0, m_udpdata_tvalid}, 72'h0);
    chk("t6_open", {71'h0, event_open_o}, 72'h0);
    chk("t6_nfrag", {62'h0, nfragment_count_o}, 72'd127);
    aresetn = 1'b1;
    rmode = 3;
    pd[0] = {48'h0, T_OP}; pk[0] = 8'hFF;
    pd[1] = {48'h0, T_ID}; pk[1] = 8'hFF;
    send_pkt(32'h0505_0505, 16'h5555, 2);
    wait_done_and_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
